// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input peripheral: register offsets,
// bus access-width encodings, default debounce reload and lane helpers.
package gpio_in_pkg;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_RISE   = 3'd1,
    REG_FALL   = 3'd2,
    REG_PEND   = 3'd3,
    REG_IRQEN  = 3'd4,
    REG_RAW    = 3'd5,
    REG_DBNC   = 3'd6,
    REG_UNUSED = 3'd7
  } reg_e;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  localparam logic [15:0] DB_DEFAULT_C = 16'd25000;

  // Byte-lane enables for a write; misaligned half/word accesses select nothing.
  function automatic logic [3:0] lane_enable(input logic [1:0] mask, input logic [1:0] addr_lo);
    logic [3:0] en;
    case (mask)
      MASK_BYTE: en = 4'b0001 << addr_lo;
      MASK_HALF: en = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
      default:   en = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// One input pin: two-flop synchroniser, saturating debounce counter and
// edge strobes that coincide with the update of the debounced level.
module gpio_debounce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_async,
  input  logic [CNT_W-1:0] d,
  output logic             stable,
  output logic             rise,
  output logic             fall,
  output logic             sync
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] deff_m1;

  always_comb begin
    deff_m1  = (d == '0) ? '0 : d - CNT_ONE;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      // ">=" lets a shortened D take effect on the next differing cycle.
      if (cnt_q >= deff_m1) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= in_async;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign sync   = sync_q;
  assign rise   = stable_d & ~stable_q;
  assign fall   = ~stable_d & stable_q;

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: per-pin debounce, edge-pending flags with
// write-one-to-clear, level interrupt and a registered-read responder port.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int               N_IN       = 8,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] DB_DEFAULT = CNT_W'(DB_DEFAULT_C)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] pins,
  input  logic            we,
  input  logic            re,
  input  logic [1:0]      mask,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  logic [N_IN-1:0]  stable, rise, fall, sync;
  logic [N_IN-1:0]  rise_en_q, rise_en_d;
  logic [N_IN-1:0]  fall_en_q, fall_en_d;
  logic [N_IN-1:0]  pend_q, pend_d;
  logic [N_IN-1:0]  irqen_q, irqen_d;
  logic [CNT_W-1:0] dbnc_q, dbnc_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [31:0]      wmask;
  logic [N_IN-1:0]  wmask_n, wdata_n, clr;
  logic [31:0]      rd_word;
  reg_e             sel;
  logic             unused_bits;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_pin
    gpio_debounce #(.CNT_W(CNT_W)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_async (pins[gi]),
      .d        (dbnc_q),
      .stable   (stable[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi]),
      .sync     (sync[gi])
    );
  end

  // Data and lane bits above the implemented register widths are don't-care.
  assign unused_bits = ^{wdata, wmask};

  always_comb begin
    sel     = reg_e'(addr[4:2]);
    wmask   = lane_bits(lane_enable(mask, addr[1:0]));
    wmask_n = wmask[N_IN-1:0];
    wdata_n = wdata[N_IN-1:0];

    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irqen_d   = irqen_q;
    dbnc_d    = dbnc_q;
    clr       = '0;
    if (we) begin
      case (sel)
        REG_RISE:  rise_en_d = (rise_en_q & ~wmask_n) | (wdata_n & wmask_n);
        REG_FALL:  fall_en_d = (fall_en_q & ~wmask_n) | (wdata_n & wmask_n);
        REG_PEND:  clr       = wdata_n & wmask_n;
        REG_IRQEN: irqen_d   = (irqen_q & ~wmask_n) | (wdata_n & wmask_n);
        REG_DBNC:  dbnc_d    = (dbnc_q & ~wmask[CNT_W-1:0]) | (wdata[CNT_W-1:0] & wmask[CNT_W-1:0]);
        default:   ;
      endcase
    end

    // New edges are ORed in after the clear so a same-cycle set wins.
    pend_d = (pend_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |(pend_q & irqen_q);

    rd_word = '0;
    case (sel)
      REG_DATA:  rd_word[N_IN-1:0]  = stable;
      REG_RISE:  rd_word[N_IN-1:0]  = rise_en_q;
      REG_FALL:  rd_word[N_IN-1:0]  = fall_en_q;
      REG_PEND:  rd_word[N_IN-1:0]  = pend_q;
      REG_IRQEN: rd_word[N_IN-1:0]  = irqen_q;
      REG_RAW:   rd_word[N_IN-1:0]  = sync;
      REG_DBNC:  rd_word[CNT_W-1:0] = dbnc_q;
      default:   rd_word = '0;
    endcase
    rdata_d = re ? rd_word : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      irqen_q   <= '0;
      dbnc_q    <= DB_DEFAULT;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      irqen_q   <= irqen_d;
      dbnc_q    <= dbnc_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in: read expectations queue up when a read is
// issued and are checked against rdata on the following clock edge.
module tb_gpio_in;
  import gpio_in_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pins;
  logic        we, re;
  logic [1:0]  mask;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  gpio_in #(.N_IN(8), .CNT_W(16), .DB_DEFAULT(16'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins),
    .we    (we),
    .re    (re),
    .mask  (mask),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct {
    logic [31:0] val;
    string       tag;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  // One clock: sample 1 ns after the edge, then score any read issued before it.
  task automatic cyc();
    logic    had_re;
    logic    had_we;
    rd_exp_t e;
    had_re = re;
    had_we = we;
    @(posedge clk);
    #1;
    if (had_we) $display("wr addr=%h mask=%b data=%h", addr, mask, wdata);
    if (had_re) begin
      e = sb_q.pop_front();
      $display("rd %s addr=%h data=%h", e.tag, addr, rdata);
      check(e.tag, rdata, e.val);
    end
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] m, input logic [4:0] a,
                     input logic [31:0] wd, input logic [31:0] expv, input string tag);
    rd_exp_t e;
    we = w; re = r; mask = m; addr = a; wdata = wd;
    if (r) begin
      e.val = expv;
      e.tag = tag;
      sb_q.push_back(e);
    end
    cyc();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] wd);
    bus(1'b1, 1'b0, MASK_WORD, a, wd, 32'h0, "");
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] expv, input string tag);
    bus(1'b0, 1'b1, MASK_WORD, a, 32'h0, expv, tag);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst_n = 1'b0; pins = 8'hFF; we = 1'b0; re = 1'b0;
    mask = MASK_WORD; addr = '0; wdata = '0;

    // 1: reset with pins high, DBNC defaults to 4
    wait_cyc(3);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);
    rd(5'h00, 32'h00, "data_edge6_pre");
    rd(5'h00, 32'hFF, "data_edge7");
    rd(5'h14, 32'hFF, "raw_high");
    rd(5'h0C, 32'h00, "pend_no_rise_en");
    check("irq_idle", {31'h0, irq}, 32'h0);

    // 2: rising edge on pin0 sets PEND then irq; short pulse on pin1 is filtered
    pins = 8'hFE;
    wr(5'h04, 32'h01);
    wr(5'h10, 32'h01);
    wait_cyc(6);
    pins = 8'hFF;
    wait_cyc(5);
    rd(5'h0C, 32'h00, "pend_cyc6_pre");
    check("irq_cyc6", {31'h0, irq}, 32'h0);
    rd(5'h0C, 32'h01, "pend_cyc7");
    check("irq_cyc7", {31'h0, irq}, 32'h1);
    pins = 8'hFD;
    for (int i = 0; i < 3; i++) rd(5'h00, 32'hFF, "glitch_data");
    pins = 8'hFF;
    for (int i = 0; i < 6; i++) rd(5'h00, 32'hFF, "glitch_after");

    // 3: W1C of PEND in the same cycle as a new rise, then a plain clear
    pins = 8'hFE;
    wait_cyc(8);
    pins = 8'hFF;
    wait_cyc(5);
    wr(5'h0C, 32'h01);
    rd(5'h0C, 32'h01, "pend_set_wins");
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    wr(5'h0C, 32'h01);
    check("irq_clr_lag", {31'h0, irq}, 32'h1);
    rd(5'h0C, 32'h00, "pend_cleared");
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // 4: D=0, all pins fall with FALL enabled; byte-lane W1C
    wr(5'h18, 32'h0);
    wr(5'h08, 32'hFF);
    pins = 8'h00;
    wait_cyc(2);
    rd(5'h00, 32'hFF, "d0_data_pre");
    rd(5'h00, 32'h00, "d0_data");
    rd(5'h0C, 32'hFF, "d0_pend_all");
    bus(1'b1, 1'b0, MASK_BYTE, 5'h0C, 32'h0000_000F, 32'h0, "");
    rd(5'h0C, 32'hF0, "pend_byte_clr");
    bus(1'b1, 1'b0, MASK_BYTE, 5'h0D, 32'h0000_00FF, 32'h0, "");
    rd(5'h0C, 32'hF0, "pend_lane1_noop");
    rd(5'h14, 32'h00, "raw_low");

    // 5: lane handling, misaligned writes, unmapped offset, read-before-write
    bus(1'b1, 1'b0, MASK_HALF, 5'h18, 32'h0000_ABCD, 32'h0, "");
    rd(5'h18, 32'hABCD, "dbnc_half");
    bus(1'b1, 1'b0, MASK_HALF, 5'h1A, 32'h1234_0000, 32'h0, "");
    rd(5'h18, 32'hABCD, "dbnc_upper_half");
    bus(1'b1, 1'b0, MASK_WORD, 5'h19, 32'h0000_1111, 32'h0, "");
    rd(5'h18, 32'hABCD, "dbnc_misaligned_word");
    bus(1'b1, 1'b0, MASK_HALF, 5'h05, 32'hFF00_FF00, 32'h0, "");
    rd(5'h04, 32'h01, "rise_misaligned_half");
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h1C, 32'h0, "unmapped_read");
    bus(1'b1, 1'b1, MASK_WORD, 5'h04, 32'h5A, 32'h01, "rise_rw_old");
    rd(5'h04, 32'h5A, "rise_rw_new");
    bus(1'b1, 1'b0, MASK_BYTE, 5'h04, 32'h33, 32'h0, "");
    rd(5'h04, 32'h33, "rise_byte0");

    // 6: reset in the middle of a debounce count with a bus access pending
    wr(5'h10, 32'hFF);
    wr(5'h18, 32'h8);
    rd(5'h04, 32'h33, "rise_before_rst");
    check("irq_before_rst", {31'h0, irq}, 32'h1);
    pins = 8'hFF;
    wait_cyc(5);
    rst_n = 1'b0;
    bus(1'b1, 1'b1, MASK_WORD, 5'h04, 32'hFF, 32'h0, "rst_overrides_rd");
    check("rst_irq_mid", {31'h0, irq}, 32'h0);
    wait_cyc(1);
    rst_n = 1'b1;
    rd(5'h04, 32'h00, "rst_rise");
    rd(5'h08, 32'h00, "rst_fall");
    rd(5'h0C, 32'h00, "rst_pend");
    rd(5'h10, 32'h00, "rst_irqen");
    rd(5'h18, 32'h04, "rst_dbnc_default");
    rd(5'h00, 32'h00, "rst_data_pre");
    rd(5'h00, 32'hFF, "rst_data_restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
